operand_packer: RTL and testbench
=================================

// Module: operand_packer
// PURPOSE
// - Upstream feeder for the two-pair adder: takes a narrow W-bit beat stream (valid/ready, last)
//   and assembles the packed operand bus ins = {s2.y, s2.x, cin, s1.y, s1.x}.
// - Presents the bus to the adder with a valid/ready handshake.
// - Holds one complete frame in an output register while the next frame assembles.
// - Detects malformed frames, drops them and resynchronises on the next in_last.
// PARAMETERS
// - W    8   operand field width; ins width is 4*W+1
// - CW  16   width of the accepted-frame counter
// PORTS
// - clk         in   1      single clock, rising edge
// - rst_n       in   1      reset, synchronous, active-low
// - in_valid    in   1      beat valid
// - in_ready    out  1      beat accepted when in_valid && in_ready
// - in_data     in   W      beat payload
// - in_last     in   1      marks the final (cin) beat of a frame
// - ins         out  4W+1   packed operands: s1.x [W-1:0], s1.y [2W-1:W], cin [2W], s2.x [3W:2W+1], s2.y [4W:3W+1]
// - ins_valid   out  1      ins holds an unconsumed frame
// - ins_ready   in   1      adder consumes ins when ins_valid && ins_ready
// - err_frame   out  1      one-cycle pulse per dropped frame
// - frame_cnt   out  CW     count of frames delivered on ins; wraps at 2^CW
// BEHAVIOUR
// - Reset (rst_n low at a clk edge):
//   - ins=0, ins_valid=0, err_frame=0, frame_cnt=0.
//   - Shadow fields cleared; state=S1X.
// - Frame beat order: s1.x, s1.y, s2.x, s2.y, cin (in_data[0] only; in_data[W-1:1] ignored).
//   - in_last is required on the cin beat and only there.
// - States: S1X -> S1Y -> S2X -> S2Y -> CIN -> S1X. DRAIN discards beats until in_last.
// - in_ready:
//   - 1 in S1X..S2Y and in DRAIN.
//   - In CIN: !ins_valid || ins_ready, so a new frame may load in the same cycle the old one is consumed.
// - Accepted beats in S1X..S2Y write the shadow field and advance the state.
// - Accepted cin beat with in_last:
//   - ins <= {shadow s2.y, s2.x, in_data[0], s1.y, s1.x}; ins_valid <= 1.
//   - frame_cnt++; state <= S1X.
//   - Latency: last beat accepted at cycle N -> ins_valid=1 at N+1.
// - ins_valid clears the cycle after ins_valid && ins_ready unless reloaded in that same cycle.
// - ins is stable while ins_valid && !ins_ready.
// - Early last (in_last accepted in S1X..S2Y):
//   - err_frame pulses; partial frame dropped; state <= S1X.
// - Missing last (cin beat accepted without in_last):
//   - err_frame pulses; beat dropped; state <= DRAIN.
//   - DRAIN: accepted beat with in_last -> S1X, no further pulse.
// - A dropped frame never touches ins, ins_valid or frame_cnt.
// - Reset mid-frame discards the shadow and any pending ins.
// PACKAGE / STRUCTURE
// - Shared package operand_pkg holds:
//   - W and the field offset localparams: S1X_LO, S1Y_LO, CIN_BIT, S2X_LO, S2Y_LO.
//   - the state enum {S1X, S1Y, S2X, S2Y, CIN, DRAIN}.
//   - The adder uses the same offsets for its slicing.
// - Single module; no sub-module needed.
//   - FSM plus shadow registers in one always_ff; output register in a second.
// TESTING
// - Beats 12,34,56,78,01(last) with ins_ready=1 -> ins=33'h0_F0AD_3412 one cycle after last;
//   frame_cnt=1; adder sm=0x115.
// - Two back-to-back frames, ins_ready=0 for 6 cycles:
//   - second frame stalls at the CIN beat (in_ready=0);
//   - ins holds frame 1; frame 2 loads in the cycle ins_ready rises.
// - in_last on the s1.y beat -> err_frame 1 cycle; ins_valid stays 0;
//   next clean frame delivered correctly.
// - cin beat without last, then 2 beats, then last -> single err_frame pulse; DRAIN exits;
//   following frame 01,02,03,04,00(last) -> ins=33'h0_0806_0201.
// - rst_n low for 1 cycle mid-frame and while ins_valid=1 -> all outputs 0 next cycle;
//   the partial frame is not delivered.
// - 2^CW+1 frames -> frame_cnt wraps to 1.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared definitions for the operand packer and the two-pair adder.
// Holds the operand field width, the bit offsets of each field on the packed
// ins bus, the packer state encoding and the packed payload layout.
package operand_pkg;

    localparam int unsigned W       = 8;
    localparam int unsigned INS_W   = 4 * W + 1;

    // Field offsets on ins; the adder slices with the same constants.
    localparam int unsigned S1X_LO  = 0;
    localparam int unsigned S1Y_LO  = W;
    localparam int unsigned CIN_BIT = 2 * W;
    localparam int unsigned S2X_LO  = 2 * W + 1;
    localparam int unsigned S2Y_LO  = 3 * W + 1;

    typedef enum logic [2:0] {
        S1X   = 3'd0,
        S1Y   = 3'd1,
        S2X   = 3'd2,
        S2Y   = 3'd3,
        CIN   = 3'd4,
        DRAIN = 3'd5
    } state_t;

    // Packed payload, MSB first, so it lines up with the offsets above.
    typedef struct packed {
        logic [W-1:0] s2y;
        logic [W-1:0] s2x;
        logic         cin;
        logic [W-1:0] s1y;
        logic [W-1:0] s1x;
    } ins_t;

endpackage

// File: rtl/operand_packer.sv
// operand_packer: assembles a W-bit beat stream into the packed adder operand
// bus ins = {s2.y, s2.x, cin, s1.y, s1.x} and hands it over with valid/ready.
// Malformed frames are dropped with a one-cycle err_frame pulse.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     beat handshake; in_data payload, in_last on cin beat
//   ins/ins_valid/ins_ready  packed operand output and its handshake
//   err_frame             one-cycle pulse per dropped frame
//   frame_cnt             frames delivered on ins, wraps at 2^CW
module operand_packer
    import operand_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic [INS_W-1:0] ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic             err_frame,
    output logic [CW-1:0]    frame_cnt
);

    state_t       state;
    state_t       state_nxt;
    logic         accept_c;
    logic         load_c;
    logic         err_c;
    logic [W-1:0] s1x_q;
    logic [W-1:0] s1y_q;
    logic [W-1:0] s2x_q;
    logic [W-1:0] s2y_q;
    ins_t         ins_pack_c;

    // The cin beat may only land when the output register is free or draining now.
    always_comb begin
        in_ready = 1'b1;
        if (state == CIN) begin
            in_ready = !ins_valid || ins_ready;
        end
    end

    assign accept_c = in_valid && in_ready;

    // Next-state and frame-completion decode.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        err_c     = 1'b0;
        case (state)
            S1X, S1Y, S2X, S2Y: begin
                if (accept_c) begin
                    if (in_last) begin
                        // Early last: drop the partial frame and restart.
                        err_c     = 1'b1;
                        state_nxt = S1X;
                    end else begin
                        case (state)
                            S1X:     state_nxt = S1Y;
                            S1Y:     state_nxt = S2X;
                            S2X:     state_nxt = S2Y;
                            default: state_nxt = CIN;
                        endcase
                    end
                end
            end
            CIN: begin
                if (accept_c) begin
                    if (in_last) begin
                        load_c    = 1'b1;
                        state_nxt = S1X;
                    end else begin
                        // Missing last: resynchronise on the next in_last.
                        err_c     = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept_c && in_last) begin
                    state_nxt = S1X;
                end
            end
            default: state_nxt = S1X;
        endcase
    end

    // State register and shadow operand fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S1X;
            s1x_q <= '0;
            s1y_q <= '0;
            s2x_q <= '0;
            s2y_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept_c && !in_last) begin
                case (state)
                    S1X:     s1x_q <= in_data;
                    S1Y:     s1y_q <= in_data;
                    S2X:     s2x_q <= in_data;
                    S2Y:     s2y_q <= in_data;
                    default: ;
                endcase
            end
        end
    end

    // Payload formed from the shadow fields plus the live cin bit.
    always_comb begin
        ins_pack_c     = '0;
        ins_pack_c.s1x = s1x_q;
        ins_pack_c.s1y = s1y_q;
        ins_pack_c.cin = in_data[0];
        ins_pack_c.s2x = s2x_q;
        ins_pack_c.s2y = s2y_q;
    end

    // Output register: a reload takes priority over the consume-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ins       <= '0;
            ins_valid <= 1'b0;
            err_frame <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_frame <= err_c;
            if (load_c) begin
                ins       <= ins_pack_c;
                ins_valid <= 1'b1;
                frame_cnt <= frame_cnt + CW'(1);
            end else if (ins_valid && ins_ready) begin
                ins_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_packer.sv
// Testbench for operand_packer: directed frames, expected payloads queued on
// issue and checked by an independent monitor when ins is consumed.
module tb_operand_packer;
    import operand_pkg::*;

    localparam int unsigned TB_CW = 8;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [TB_CW-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic [INS_W-1:0] ins;
    logic             ins_valid;
    logic             ins_ready;
    logic             err_frame;
    logic [TB_CW-1:0] frame_cnt;

    exp_t             sb[$];
    int               checks;
    int               failures;
    int               err_seen;
    logic [TB_CW-1:0] exp_cnt;

    operand_packer #(.CW(TB_CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [INS_W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic [W-1:0] d,
                                              input logic cin);
        return {d, c, cin, b, a};
    endfunction

    // Monitor: pops one expectation per consumed frame and counts err pulses.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (err_frame) err_seen++;
            if (ins_valid && ins_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%0h required=none", ins);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ins", 64'(ins), 64'(e.ins));
                    check("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                end
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=stalled required=accepted");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [INS_W-1:0] e);
        exp_cnt = exp_cnt + TB_CW'(1);
        sb.push_back('{ins: e, cnt: exp_cnt});
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic [W-1:0] d, input logic [W-1:0] cin,
                              input logic [INS_W-1:0] e);
        push_exp(e);
        send_beat(a, 1'b0);
        send_beat(b, 1'b0);
        send_beat(c, 1'b0);
        send_beat(d, 1'b0);
        send_beat(cin, 1'b1);
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        #1;
    endtask

    initial begin
        int err0;
        checks    = 0;
        failures  = 0;
        err_seen  = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        ins_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ins", 64'(ins), 64'd0);
        check("rst_ins_valid", 64'(ins_valid), 64'd0);
        check("rst_err_frame", 64'(err_frame), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Basic frame and one-cycle latency.
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 33'h0_F0AD_3412);
        #1;
        check("lat_ins_valid", 64'(ins_valid), 64'd1);
        check("lat_ins", 64'(ins), 64'h0_F0AD_3412);
        check("lat_frame_cnt", 64'(frame_cnt), 64'd1);
        idle();
        wait_sb_empty();

        // Back-to-back frames with the consumer stalled.
        push_exp(33'h0_8866_2211);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        ins_ready = 1'b0;
        send_beat(8'h00, 1'b1);
        push_exp(33'h1_BB99_BBAA);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b0);
        send_beat(8'hDD, 1'b0);
        @(negedge clk);
        in_data = 8'hFF;
        in_last = 1'b1;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_ins_hold", 64'(ins), 64'h0_8866_2211);
        check("stall_ins_valid", 64'(ins_valid), 64'd1);
        @(negedge clk);
        #1;
        check("stall_in_ready2", 64'(in_ready), 64'd0);
        check("stall_ins_hold2", 64'(ins), 64'h0_8866_2211);
        ins_ready = 1'b1;
        #0.5;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("reload_ins", 64'(ins), 64'h1_BB99_BBAA);
        check("reload_ins_valid", 64'(ins_valid), 64'd1);
        idle();
        wait_sb_empty();

        // Early last on the s1.y beat.
        err0 = err_seen;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        #3;
        check("early_err_pulses", 64'(err_seen - err0), 64'd1);
        check("early_ins_valid", 64'(ins_valid), 64'd0);
        check("early_frame_cnt", 64'(frame_cnt), 64'd3);
        send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 33'h0_100F_0605);
        idle();
        wait_sb_empty();

        // Missing last, drain, then resynchronised frame.
        err0 = err_seen;
        send_beat(8'h31, 1'b0);
        send_beat(8'h32, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h34, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h41, 1'b0);
        send_beat(8'h42, 1'b0);
        send_beat(8'h43, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        #3;
        check("drain_err_pulses", 64'(err_seen - err0), 64'd1);
        check("drain_ins_valid", 64'(ins_valid), 64'd0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 33'h0_0806_0201);
        idle();
        wait_sb_empty();
        check("drain_frame_cnt", 64'(frame_cnt), 64'd5);

        // Reset while a frame is pending and another is half assembled.
        ins_ready = 1'b0;
        send_beat(8'h09, 1'b0);
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0B, 1'b0);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h01, 1'b1);
        send_beat(8'h5A, 1'b0);
        send_beat(8'h5B, 1'b0);
        idle();
        #1;
        check("pre_rst_ins_valid", 64'(ins_valid), 64'd1);
        do_reset();
        check("mid_rst_ins", 64'(ins), 64'd0);
        check("mid_rst_ins_valid", 64'(ins_valid), 64'd0);
        check("mid_rst_err_frame", 64'(err_frame), 64'd0);
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        ins_ready = 1'b1;
        send_frame(8'h21, 8'h43, 8'h65, 8'h07, 8'h01, 33'h0_0ECB_4321);
        idle();
        wait_sb_empty();

        // Counter wrap: 2^CW + 1 frames after reset.
        do_reset();
        for (int i = 0; i < (1 << TB_CW) + 1; i++) begin
            logic [W-1:0] a;
            a = W'(i);
            send_frame(a, a ^ 8'h5A, a + 8'h11, ~a, {7'd0, a[0]},
                       pack(a, a ^ 8'h5A, a + 8'h11, ~a, a[0]));
        end
        idle();
        wait_sb_empty();
        check("wrap_frame_cnt", 64'(frame_cnt), 64'd1);
        check("total_err_pulses", 64'(err_seen), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
